// File: rtl/cic_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_comp_pkg
// Description : Shared types, constants and helpers for the CIC compensation
//               FIR family (interpolating and decimating variants).
// Revision    : 1.0 - initial release
// ============================================================================
package cic_comp_pkg;

    // Controller states shared by the compensation filters
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Cycles needed to flush read -> multiply -> accumulate after the last issue
    localparam int DRAIN_CYCLES = 3;

    // Default ROM geometry: two branches of 17 taps, 15-bit signed words
    localparam int DEF_TAPS = 17;
    localparam int DEF_CW   = 15;

    // Default compensation ROM image: words 0..16 branch 0, 17..33 branch 1
    localparam int COEF_TAB [2*DEF_TAPS] = '{
        -12,  35,  -80, 160, -290, 490, -820, 1450, 12000, 3100,
        -1100, 560, -300, 150,  -70,  28,   -9,
        -5,   20,  -55, 120, -230, 400, -700, 1200,  4200, 11800,
        -1300, 620, -330, 170,  -80,  32,  -11
    };

    // Pack the default table into the flat vector the ROM parameter expects
    function automatic logic [2*DEF_TAPS*DEF_CW-1:0] default_coeffs();
        logic [2*DEF_TAPS*DEF_CW-1:0] v;
        v = '0;
        for (int k = 0; k < 2*DEF_TAPS; k++) begin
            v[k*DEF_CW +: DEF_CW] = DEF_CW'(COEF_TAB[k]);
        end
        return v;
    endfunction

    // Round half-up, arithmetic shift right, clamp to a dw_out-bit signed range
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                      input int shift,
                                                      input int dw_out);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        max_v = (64'sd1 <<< (dw_out - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (dw_out - 1));
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_comp_mac_core.sv
`default_nettype none
// ============================================================================
// Module      : cic_comp_mac_core
// Description : Sample buffer, coefficient ROM and a three-stage
//               read -> multiply -> accumulate pipeline. One address pair is
//               accepted per cycle while 'issue' is high; 'clear' zeroes the
//               accumulator and flushes the pipeline valids.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_comp_mac_core
    import cic_comp_pkg::*;
#(
    parameter int DW_IN           = 16,
    parameter int CW              = 15,
    parameter int DW_ACC          = 32,
    parameter int POLYPHASE_DEPTH = 17,
    parameter int DEPTH           = 32,
    parameter logic [2*POLYPHASE_DEPTH*CW-1:0] COEFFS = default_coeffs(),
    localparam int AW  = $clog2(DEPTH),
    localparam int CIW = $clog2(2*POLYPHASE_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [DW_IN-1:0]  wr_data,
    input  logic                     clear,
    input  logic                     issue,
    input  logic [AW-1:0]            rd_addr,
    input  logic [CIW-1:0]           coeff_idx,
    output logic signed [DW_ACC-1:0] acc
);

    localparam int PW = DW_IN + CW;

    logic signed [DW_IN-1:0] mem [DEPTH];
    logic signed [DW_IN-1:0] r_sample;
    logic signed [CW-1:0]    r_coeff;
    logic signed [PW-1:0]    r_prod;
    logic                    r_vld_rd;
    logic                    r_vld_mul;

    // Buffer write port; contents are cleared by the controller's INIT sweep
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read, multiply and accumulate stages, each one register deep
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample  <= '0;
            r_coeff   <= '0;
            r_prod    <= '0;
            r_vld_rd  <= 1'b0;
            r_vld_mul <= 1'b0;
            acc       <= '0;
        end else begin
            r_sample  <= mem[rd_addr];
            r_coeff   <= $signed(COEFFS[int'(coeff_idx)*CW +: CW]);
            r_vld_rd  <= issue & ~clear;
            r_prod    <= PW'(r_sample) * PW'(r_coeff);
            r_vld_mul <= r_vld_rd & ~clear;
            if (clear) begin
                acc <= '0;
            end else if (r_vld_mul) begin
                acc <= acc + DW_ACC'(r_prod);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_comp_up_mac.sv
`default_nettype none
// ============================================================================
// Module      : cic_comp_up_mac
// Description : Interpolate-by-2 CIC compensation FIR. Each accepted tick
//               evaluates one polyphase branch on a shared MAC and publishes
//               the previous tick's result. The coefficient ROM image is the
//               packed COEFFS vector (word k at bits [k*CW +: CW]).
// Revision    : 1.0 - initial release
// ============================================================================
module cic_comp_up_mac
    import cic_comp_pkg::*;
#(
    parameter int DW_IN           = 16,
    parameter int DW_OUT          = 16,
    parameter int DW_ACC          = 32,
    parameter int CW              = 15,
    parameter int POLYPHASE_DEPTH = 17,
    parameter int DEPTH           = 32,
    parameter int SHIFT           = 14,
    parameter logic [2*POLYPHASE_DEPTH*CW-1:0] COEFFS = default_coeffs()
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clk_enable,
    input  logic signed [DW_IN-1:0]  filter_in,
    output logic signed [DW_OUT-1:0] filter_out,
    output logic                     ce_out,
    output logic                     overrun
);

    localparam int AW  = $clog2(DEPTH);
    localparam int TW  = $clog2(POLYPHASE_DEPTH);
    localparam int CIW = $clog2(2*POLYPHASE_DEPTH);

    state_t                  r_state;
    logic                    r_phase;
    logic                    r_branch;
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_base;
    logic [AW-1:0]           r_init_cnt;
    logic [TW-1:0]           r_tap;
    logic [1:0]              r_drain;
    logic signed [DW_OUT-1:0] r_result;

    logic                    w_tick_ok;
    logic                    w_wr_en;
    logic [AW-1:0]           w_wr_addr;
    logic signed [DW_IN-1:0] w_wr_data;
    logic [AW-1:0]           w_rd_addr;
    logic [CIW-1:0]          w_coeff_idx;
    logic signed [DW_ACC-1:0] w_acc;
    logic signed [DW_OUT-1:0] w_rounded;

    // Only a tick seen in IDLE starts work; INIT ticks are silently dropped
    assign w_tick_ok   = clk_enable && (r_state == ST_IDLE);
    assign w_wr_en     = (r_state == ST_INIT) || (w_tick_ok && !r_phase);
    assign w_wr_addr   = (r_state == ST_INIT) ? r_init_cnt : r_wptr;
    assign w_wr_data   = (r_state == ST_INIT) ? '0 : filter_in;
    assign w_rd_addr   = r_base - AW'(r_tap);
    assign w_coeff_idx = r_branch ? (CIW'(POLYPHASE_DEPTH) + CIW'(r_tap)) : CIW'(r_tap);
    assign w_rounded   = DW_OUT'(round_sat(64'(w_acc), SHIFT, DW_OUT));

    cic_comp_mac_core #(
        .DW_IN           (DW_IN),
        .CW              (CW),
        .DW_ACC          (DW_ACC),
        .POLYPHASE_DEPTH (POLYPHASE_DEPTH),
        .DEPTH           (DEPTH),
        .COEFFS          (COEFFS)
    ) u_mac (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (w_wr_en),
        .wr_addr   (w_wr_addr),
        .wr_data   (w_wr_data),
        .clear     (r_state == ST_LOAD),
        .issue     (r_state == ST_RUN),
        .rd_addr   (w_rd_addr),
        .coeff_idx (w_coeff_idx),
        .acc       (w_acc)
    );

    // Controller: buffer init, tick acceptance, MAC sequencing and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_phase    <= 1'b0;
            r_branch   <= 1'b0;
            r_wptr     <= '0;
            r_base     <= '0;
            r_init_cnt <= '0;
            r_tap      <= '0;
            r_drain    <= '0;
            r_result   <= '0;
            filter_out <= '0;
            ce_out     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            ce_out <= 1'b0;
            if (clk_enable && (r_state != ST_INIT) && (r_state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + AW'(1);
                    if (r_init_cnt == AW'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_tick_ok) begin
                        filter_out <= r_result;
                        ce_out     <= 1'b1;
                        r_phase    <= ~r_phase;
                        r_branch   <= r_phase;
                        if (!r_phase) begin
                            r_base <= r_wptr;
                            r_wptr <= r_wptr + AW'(1);
                        end else begin
                            // Branch 1 reuses the newest sample written by the phase-0 tick
                            r_base <= r_wptr - AW'(1);
                        end
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_tap   <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_tap <= r_tap + TW'(1);
                    if (r_tap == TW'(POLYPHASE_DEPTH - 1)) begin
                        r_drain <= '0;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_drain <= r_drain + 2'd1;
                    if (r_drain == 2'(DRAIN_CYCLES - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_result <= w_rounded;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
